iq_ser_reader: RTL



---
 rtl/iq_ser_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/iq_ser_reader.sv
// Serial IQ readout receiver: shifts one channel's 84-bit accumulator register in,
// then presents a status word and six sign-extended accumulators over valid/ready.
module iq_ser_reader #(
    parameter int NCH = 12,
    parameter int W   = 14,
    parameter int NF  = 6,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [CW-1:0]  chan,
    output logic           busy,
    output logic           cmd_err,
    input  logic [NCH-1:0] epoch,
    input  logic [NCH-1:0] sout,
    output logic [NCH-1:0] shift,
    output logic [15:0]    rd_data,
    output logic           rd_valid,
    input  logic           rd_ready,
    output logic [NCH-1:0] fresh
);

    localparam int NB = NF * W;
    localparam int BW = $clog2(NB + 1);
    localparam int IW = $clog2(NF + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

    logic [1:0]     state;
    logic [CW-1:0]  sel;
    logic [NB-1:0]  cap;
    logic [BW-1:0]  bit_cnt;
    logic [IW-1:0]  idx;
    logic [NCH-1:0] missed;
    logic           fresh_snap;
    logic           missed_snap;
    logic           overrun;
    logic           accept;

    function automatic logic [15:0] sext(input logic [W-1:0] f);
        return {{(16 - W){f[W-1]}}, f};
    endfunction

    assign accept   = start && (state == IDLE) && ({1'b0, chan} < (CW + 1)'(NCH));
    assign busy     = (state != IDLE);
    assign rd_valid = (state == OUT);

    // Strobe decoded from registered state so an async reset removes it at once.
    always_comb begin
        shift = '0;
        if (state == SHIFT)
            shift[sel] = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        if (state == OUT) begin
            if (idx == '0)
                rd_data = {fresh_snap, missed_snap, overrun, 5'b0, 8'(sel)};
            for (int k = 1; k <= NF; k++)
                if (idx == IW'(k))
                    rd_data = sext(cap[NB - 1 - W * (k - 1) -: W]);
        end
    end

    // Epoch tracking runs in every state; a set beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fresh  <= '0;
            missed <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (epoch[c])
                    fresh[c] <= 1'b1;
                else if (accept && chan == CW'(c))
                    fresh[c] <= 1'b0;
                if (epoch[c] && fresh[c])
                    missed[c] <= 1'b1;
                else if (accept && chan == CW'(c))
                    missed[c] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            cap         <= '0;
            bit_cnt     <= '0;
            idx         <= '0;
            fresh_snap  <= 1'b0;
            missed_snap <= 1'b0;
            overrun     <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            cmd_err <= start && !accept;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sel         <= chan;
                        fresh_snap  <= fresh[chan];
                        missed_snap <= missed[chan];
                        overrun     <= epoch[chan];
                        bit_cnt     <= '0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    cap     <= {cap[NB-2:0], sout[sel]};
                    overrun <= overrun | epoch[sel];
                    if (bit_cnt == BW'(NB - 1)) begin
                        bit_cnt <= '0;
                        idx     <= '0;
                        state   <= OUT;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (rd_ready) begin
                        if (idx == IW'(NF)) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
